// File: rtl/pkt_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : pkt_mux_arb
// Brief   : Two-channel store-and-forward packet arbiter/merger for the
//           134-bit packet bus; grants whole packets to the tx port.
// Revision: 1.0 - initial release
// ============================================================================
module pkt_mux_arb #(
   parameter int DATA_DEPTH  = 256,
   parameter int ALF_GAP     = 100,
   parameter int STRICT_PRIO = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in0_data_wr,
   input  logic [133:0] in0_data,
   input  logic         in0_data_valid,
   input  logic         in0_data_valid_wr,
   output logic         in0_alf,
   input  logic         in1_data_wr,
   input  logic [133:0] in1_data,
   input  logic         in1_data_valid,
   input  logic         in1_data_valid_wr,
   output logic         in1_alf,
   output logic         mux2tx_data_wr,
   output logic [133:0] mux2tx_data,
   output logic         mux2tx_data_valid,
   output logic         mux2tx_data_valid_wr,
   input  logic         tx2mux_data_alf
);

   localparam int         c_AW   = $clog2(DATA_DEPTH);
   localparam int         c_DW   = 134;
   localparam logic [1:0] c_HEAD = 2'b01;
   localparam logic [1:0] c_TAIL = 2'b10;

   typedef enum logic {WR_WAIT_HEAD = 1'b0, WR_WRITE = 1'b1} wr_state_t;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_READ = 1'b1} arb_state_t;

   logic [1:0]           w_in_wr, w_in_valid, w_in_vwr, w_alf, w_pkt_avail, w_rd_en;
   logic [1:0][c_DW-1:0] w_in_data, w_rd_word;

   assign w_in_wr    = {in1_data_wr, in0_data_wr};
   assign w_in_valid = {in1_data_valid, in0_data_valid};
   assign w_in_vwr   = {in1_data_valid_wr, in0_data_valid_wr};
   assign w_in_data  = {in1_data, in0_data};
   assign in0_alf    = w_alf[0];
   assign in1_alf    = w_alf[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         wr_state_t        r_state, w_state_nxt;
         logic [c_AW-1:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr;
         logic [c_AW:0]    r_used, r_unc, r_pkt_cnt, w_used_nxt;
         logic             r_bad, r_last_tail, r_alf;
         logic             w_full, w_wr_en, w_word_bad, w_commit, w_drop, w_last_tail, w_rd_tail;
         logic [1:0]       w_type;
         logic [c_DW-1:0]  r_mem [DATA_DEPTH];

         assign w_type    = w_in_data[gi][133:132];
         assign w_full    = (r_used == (c_AW+1)'(DATA_DEPTH));
         assign w_rd_tail = w_rd_en[gi] && (w_rd_word[gi][133:132] == c_TAIL);

         always_comb begin
            w_state_nxt = r_state;
            w_wr_en     = 1'b0;
            w_word_bad  = 1'b0;
            w_commit    = 1'b0;
            w_drop      = 1'b0;
            w_last_tail = r_last_tail;
            case (r_state)
               WR_WAIT_HEAD: begin
                  if (w_in_wr[gi] && (w_type == c_HEAD)) begin
                     w_wr_en     = !w_full;
                     w_word_bad  = w_full;
                     w_last_tail = 1'b0;
                     w_state_nxt = WR_WRITE;
                  end
               end
               default: begin
                  if (w_in_wr[gi]) begin
                     w_wr_en     = !w_full;
                     w_word_bad  = w_full || (w_type == c_HEAD);
                     w_last_tail = (w_type == c_TAIL);
                  end
                  // A committed packet must end in a tail so the reader can find its end
                  if (w_in_vwr[gi]) begin
                     w_commit    = w_in_valid[gi] && !r_bad && !w_word_bad && w_last_tail;
                     w_drop      = !w_commit;
                     w_state_nxt = WR_WAIT_HEAD;
                  end
               end
            endcase
            if (w_drop)
               w_used_nxt = r_used - r_unc - (c_AW+1)'(w_rd_en[gi]);
            else
               w_used_nxt = r_used + (c_AW+1)'(w_wr_en) - (c_AW+1)'(w_rd_en[gi]);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_state      <= WR_WAIT_HEAD;
               r_wr_ptr     <= '0;
               r_commit_ptr <= '0;
               r_rd_ptr     <= '0;
               r_used       <= '0;
               r_unc        <= '0;
               r_pkt_cnt    <= '0;
               r_bad        <= 1'b0;
               r_last_tail  <= 1'b0;
               r_alf        <= 1'b0;
            end else begin
               r_state     <= w_state_nxt;
               r_used      <= w_used_nxt;
               r_alf       <= (((c_AW+1)'(DATA_DEPTH) - w_used_nxt) < (c_AW+1)'(ALF_GAP));
               r_last_tail <= w_last_tail;
               r_bad       <= (w_state_nxt == WR_WAIT_HEAD) ? 1'b0 : (r_bad | w_word_bad);
               if (w_wr_en)
                  r_wr_ptr <= r_wr_ptr + 1'b1;
               if (w_commit) begin
                  r_commit_ptr <= w_wr_en ? r_wr_ptr + 1'b1 : r_wr_ptr;
                  r_unc        <= '0;
               end else if (w_drop) begin
                  r_wr_ptr <= r_commit_ptr;
                  r_unc    <= '0;
               end else if (w_wr_en) begin
                  r_unc <= r_unc + 1'b1;
               end
               if (w_commit && !w_rd_tail)
                  r_pkt_cnt <= r_pkt_cnt + 1'b1;
               else if (!w_commit && w_rd_tail)
                  r_pkt_cnt <= r_pkt_cnt - 1'b1;
               if (w_rd_en[gi])
                  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (w_wr_en)
               r_mem[r_wr_ptr] <= w_in_data[gi];
         end

         assign w_rd_word[gi]   = r_mem[r_rd_ptr];
         assign w_pkt_avail[gi] = (r_pkt_cnt != '0);
         assign w_alf[gi]       = r_alf;
      end
   endgenerate

   arb_state_t      r_arb_state, w_arb_nxt;
   logic            r_gnt, w_gnt_nxt, r_rr_next, w_out_tail;
   logic [c_DW-1:0] w_sel_word;

   always_comb begin
      w_arb_nxt  = r_arb_state;
      w_gnt_nxt  = r_gnt;
      w_rd_en    = 2'b00;
      w_sel_word = w_rd_word[r_gnt];
      w_out_tail = 1'b0;
      case (r_arb_state)
         ARB_IDLE: begin
            if (!tx2mux_data_alf && (w_pkt_avail != 2'b00)) begin
               w_arb_nxt = ARB_READ;
               if (STRICT_PRIO != 0)
                  w_gnt_nxt = w_pkt_avail[1];
               else
                  w_gnt_nxt = w_pkt_avail[r_rr_next] ? r_rr_next : !r_rr_next;
            end
         end
         default: begin
            w_rd_en[r_gnt] = 1'b1;
            w_out_tail     = (w_sel_word[133:132] == c_TAIL);
            if (w_out_tail)
               w_arb_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_arb_state          <= ARB_IDLE;
         r_gnt                <= 1'b0;
         r_rr_next            <= 1'b0;
         mux2tx_data_wr       <= 1'b0;
         mux2tx_data          <= '0;
         mux2tx_data_valid    <= 1'b0;
         mux2tx_data_valid_wr <= 1'b0;
      end else begin
         r_arb_state          <= w_arb_nxt;
         r_gnt                <= w_gnt_nxt;
         mux2tx_data_wr       <= (r_arb_state == ARB_READ);
         mux2tx_data          <= (r_arb_state == ARB_READ) ? w_sel_word : '0;
         mux2tx_data_valid    <= w_out_tail;
         mux2tx_data_valid_wr <= w_out_tail;
         if (w_out_tail)
            r_rr_next <= !r_gnt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pkt_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_pkt_mux_arb
// Brief   : Self-checking bench for pkt_mux_arb (vector table, directed
//           corner sequences and randomized traffic against a queue model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pkt_mux_arb;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in0_data_wr = 1'b0, in0_data_valid = 1'b0, in0_data_valid_wr = 1'b0;
   logic [133:0] in0_data = '0;
   logic         in1_data_wr = 1'b0, in1_data_valid = 1'b0, in1_data_valid_wr = 1'b0;
   logic [133:0] in1_data = '0;
   logic         tx_alf = 1'b1, tx_alf1 = 1'b1;
   logic         in0_alf, in1_alf, o_wr, o_vld, o_vwr;
   logic [133:0] o_data;
   logic         p_alf0, p_alf1, p_wr, p_vld, p_vwr;
   logic [133:0] p_data;

   pkt_mux_arb #(.DATA_DEPTH(256), .ALF_GAP(100), .STRICT_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .in0_data_wr(in0_data_wr), .in0_data(in0_data), .in0_data_valid(in0_data_valid),
      .in0_data_valid_wr(in0_data_valid_wr), .in0_alf(in0_alf),
      .in1_data_wr(in1_data_wr), .in1_data(in1_data), .in1_data_valid(in1_data_valid),
      .in1_data_valid_wr(in1_data_valid_wr), .in1_alf(in1_alf),
      .mux2tx_data_wr(o_wr), .mux2tx_data(o_data), .mux2tx_data_valid(o_vld),
      .mux2tx_data_valid_wr(o_vwr), .tx2mux_data_alf(tx_alf)
   );

   pkt_mux_arb #(.DATA_DEPTH(256), .ALF_GAP(100), .STRICT_PRIO(1)) dut_sp (
      .clk(clk), .rst(rst),
      .in0_data_wr(in0_data_wr), .in0_data(in0_data), .in0_data_valid(in0_data_valid),
      .in0_data_valid_wr(in0_data_valid_wr), .in0_alf(p_alf0),
      .in1_data_wr(in1_data_wr), .in1_data(in1_data), .in1_data_valid(in1_data_valid),
      .in1_data_valid_wr(in1_data_valid_wr), .in1_alf(p_alf1),
      .mux2tx_data_wr(p_wr), .mux2tx_data(p_data), .mux2tx_data_valid(p_vld),
      .mux2tx_data_valid_wr(p_vwr), .tx2mux_data_alf(tx_alf1)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0, word_cnt = 0, last_tail = -10, cur_ch = 0;
   bit in_pkt = 1'b0, done = 1'b0;
   int pid [2];
   logic [133:0] exp0 [$];
   logic [133:0] exp1 [$];
   int order_q [$];
   int order1_q [$];

   typedef struct {
      int ch; int len; bit vld; bit late; bit dup; bit stray; bit exp_out;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [133:0] mk(input int ch, input int p, input int idx, input int len);
      logic [1:0] t;
      t = (idx == 0) ? 2'b01 : ((idx == len - 1) ? 2'b10 : 2'b11);
      return {t, 4'b0, ch[0], p[14:0], idx[15:0], $urandom, $urandom, $urandom};
   endfunction

   task automatic drv(input int ch, input logic wr, input logic [133:0] d, input logic v, input logic vw);
      if (ch == 0) begin
         in0_data_wr = wr; in0_data = d; in0_data_valid = v; in0_data_valid_wr = vw;
      end else begin
         in1_data_wr = wr; in1_data = d; in1_data_valid = v; in1_data_valid_wr = vw;
      end
   endtask

   task automatic push_exp(input int ch, input logic [133:0] w);
      if (ch == 0) exp0.push_back(w);
      else         exp1.push_back(w);
   endtask

   // Called right after a rising edge; leaves the bus idle after the packet.
   task automatic send_pkt(input int ch, input int len, input bit vld, input bit late,
                           input bit dup, input bit stray, input bit exp_out);
      logic [133:0] w;
      int p;
      p = pid[ch];
      pid[ch]++;
      if (stray) begin
         w = mk(ch, p, 1, len);
         w[133:132] = 2'b11;
         drv(ch, 1'b1, w, 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      for (int i = 0; i < len; i++) begin
         w = mk(ch, p, i, len);
         if (dup && i == 1) w[133:132] = 2'b01;
         if (exp_out) push_exp(ch, w);
         drv(ch, 1'b1, w, vld, !late && (i == len - 1));
         @(posedge clk); #1;
      end
      if (late) begin
         drv(ch, 1'b0, '0, vld, 1'b1);
         @(posedge clk); #1;
      end
      drv(ch, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0 || in_pkt) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk_i("drain", exp0.size() + exp1.size() + int'(in_pkt), 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp0.delete(); exp1.delete(); order_q.delete(); order1_q.delete();
   endtask

   task automatic wait_out(input int budget);
      int n = 0;
      while (!o_wr && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("out_start", 134'(o_wr), 134'(1));
   endtask

   task automatic rand_ch(input int ch);
      int len;
      bit vld, dup, late, stray;
      for (int k = 0; k < 25; k++) begin
         repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
         len   = int'($urandom_range(3, 8));
         vld   = ($urandom_range(0, 9) < 8);
         dup   = ($urandom_range(0, 9) == 0);
         late  = ($urandom_range(0, 1) == 1);
         stray = ($urandom_range(0, 9) == 0);
         send_pkt(ch, len, vld, late, dup, stray, vld && !dup);
      end
   endtask

   always @(posedge clk) cyc++;

   // Output monitor: packet framing, gap, flag timing and per-channel FIFO order.
   always @(negedge clk) begin
      logic [1:0] t;
      logic [133:0] e;
      if (rst) begin
         in_pkt = 1'b0;
      end else if (!o_wr) begin
         chk("idle_zero", o_data | 134'({o_vld, o_vwr}), '0);
      end else begin
         word_cnt++;
         t = o_data[133:132];
         if (t == 2'b01) begin
            chk("interleave", 134'(in_pkt), '0);
            chk("pkt_gap", 134'(cyc - last_tail >= 2), 134'(1));
            cur_ch = int'(o_data[127]);
            order_q.push_back(cur_ch);
            in_pkt = 1'b1;
         end else begin
            chk("orphan_word", 134'(in_pkt), 134'(1));
         end
         if ((cur_ch == 0 && exp0.size() == 0) || (cur_ch == 1 && exp1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: actual=%h required=none", o_data);
         end else begin
            if (cur_ch == 0) e = exp0.pop_front();
            else             e = exp1.pop_front();
            chk("data", o_data, e);
         end
         chk("valid_flags", 134'({o_vld, o_vwr}), (t == 2'b10) ? 134'(3) : 134'(0));
         if (t == 2'b10) begin
            in_pkt = 1'b0;
            last_tail = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && p_wr && p_data[133:132] == 2'b01) order1_q.push_back(int'(p_data[127]));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc, n;
      int p;
      logic [133:0] w;
      int rr_exp [6];
      int sp_exp [4];
      rr_exp = '{0, 1, 0, 1, 0, 1};
      sp_exp = '{1, 1, 0, 0};
      pid[0] = 0;
      pid[1] = 0;

      tbl[0] = '{0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{0, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      // Reset state
      do_reset();
      chk("rst_out", o_data | 134'({o_wr, o_vld, o_vwr}), '0);
      chk("rst_alf", 134'({in0_alf, in1_alf}), '0);

      // Vector table: each row's expected word count on the output
      tx_alf = 1'b0;
      for (int v = 0; v < 8; v++) begin
         wc = word_cnt;
         send_pkt(tbl[v].ch, tbl[v].len, tbl[v].vld, tbl[v].late, tbl[v].dup,
                  tbl[v].stray, tbl[v].exp_out);
         wait_drain(200);
         repeat (10) @(negedge clk);
         chk_i($sformatf("vec%0d_words", v), word_cnt - wc, tbl[v].exp_out ? tbl[v].len : 0);
      end

      // Round-robin order with both channels loaded
      do_reset();
      tx_alf = 1'b1;
      for (int k = 0; k < 3; k++) send_pkt(0, 3 + k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) send_pkt(1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tx_alf = 1'b0;
      wait_drain(400);
      chk_i("rr_count", order_q.size(), 6);
      for (int k = 0; k < 6 && k < order_q.size(); k++)
         chk_i($sformatf("rr_order%0d", k), order_q[k], rr_exp[k]);

      // Strict priority instance versus round-robin instance on the same load
      do_reset();
      tx_alf = 1'b1;
      tx_alf1 = 1'b1;
      for (int k = 0; k < 2; k++) send_pkt(0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) send_pkt(1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tx_alf1 = 1'b0;
      n = 0;
      while (order1_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
      chk_i("sp_count", order1_q.size(), 4);
      for (int k = 0; k < 4 && k < order1_q.size(); k++)
         chk_i($sformatf("sp_order%0d", k), order1_q[k], sp_exp[k]);
      tx_alf = 1'b0;
      wait_drain(300);
      chk_i("rr2_count", order_q.size(), 4);
      for (int k = 0; k < 4 && k < order_q.size(); k++)
         chk_i($sformatf("rr2_order%0d", k), order_q[k], k % 2);

      // Almost-full threshold and overfill
      do_reset();
      tx_alf = 1'b1;
      for (int k = 0; k < 3; k++) send_pkt(0, 52, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("alf_at_156", 134'(in0_alf), '0);
      p = pid[0];
      pid[0]++;
      for (int i = 0; i < 101; i++) begin
         w = mk(0, p, i, 101);
         drv(0, 1'b1, w, 1'b1, i == 100);
         @(posedge clk); #1;
         if (i == 0)  chk("alf_at_157", 134'(in0_alf), 134'(1));
         if (i == 99) chk("alf_at_full", 134'(in0_alf), 134'(1));
      end
      drv(0, 1'b0, '0, 1'b0, 1'b0);
      chk("alf_after_drop", 134'(in0_alf), '0);
      send_pkt(0, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("alf_exact_full", 134'(in0_alf), 134'(1));
      tx_alf = 1'b0;
      wait_drain(1000);
      chk("alf_emptied", 134'(in0_alf), '0);

      // Downstream almost-full: block, finish the packet in flight, resume
      tx_alf = 1'b1;
      send_pkt(0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_pkt(0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wc = word_cnt;
      repeat (20) @(negedge clk);
      chk_i("alf_block", word_cnt - wc, 0);
      tx_alf = 1'b0;
      wait_out(20);
      tx_alf = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      chk_i("alf_mid_pkt_left", exp0.size(), 6);
      chk("alf_mid_pkt_closed", 134'(in_pkt), '0);
      tx_alf = 1'b0;
      wait_drain(200);

      // Reset in the middle of an output packet
      tx_alf = 1'b1;
      send_pkt(0, 40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_pkt(1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tx_alf = 1'b0;
      wait_out(20);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_data", o_data, '0);
      chk("rst_mid_flags", 134'({o_wr, o_vld, o_vwr}), '0);
      chk("rst_mid_alf", 134'({in0_alf, in1_alf}), '0);
      rst = 1'b0;
      exp0.delete();
      exp1.delete();
      wc = word_cnt;
      repeat (40) @(negedge clk);
      chk_i("rst_no_output", word_cnt - wc, 0);
      @(posedge clk); #1;
      send_pkt(1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_drain(100);

      // Randomized concurrent traffic with random downstream backpressure
      do_reset();
      done = 1'b0;
      fork
         begin
            fork
               rand_ch(0);
               rand_ch(1);
            join
            done = 1'b1;
         end
         begin
            while (!done) begin
               tx_alf = ($urandom_range(0, 3) == 0);
               repeat ($urandom_range(1, 10)) begin @(posedge clk); #1; end
            end
         end
      join
      tx_alf = 1'b0;
      wait_drain(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
